// File: rtl/swc_pktmem_pkg.sv
// Shared constants and types for the switch-core packet buffer.
//   Geometry: 65536 words in 4096 lines of 16 words; a page is 4 lines, so a
//   line address is {page[9:0], offset[1:0]}. A stored word is {ctrl, data}.
//   Optional feature macro used by the design files: SWC_PKTMEM_FLUSH_ZERO_EN.
package swc_pktmem_pkg;
  localparam int C_NUM_PORTS      = 11;
  localparam int C_MEM_SIZE       = 65536;
  localparam int C_MULTIPLY       = 16;
  localparam int C_DATA_W         = 16;
  localparam int C_CTRL_W         = 16;
  localparam int C_PAGE_SIZE      = 64;

  localparam int C_LINES_PER_PAGE = C_PAGE_SIZE / C_MULTIPLY;       // 4
  localparam int C_NUM_LINES      = C_MEM_SIZE / C_MULTIPLY;        // 4096
  localparam int C_NUM_PAGES      = C_MEM_SIZE / C_PAGE_SIZE;       // 1024
  localparam int C_PAGE_AW        = $clog2(C_NUM_PAGES);            // 10
  localparam int C_OFFS_AW        = $clog2(C_LINES_PER_PAGE);       // 2
  localparam int C_LINE_AW        = C_PAGE_AW + C_OFFS_AW;          // 12
  localparam int C_IDX_W          = $clog2(C_MULTIPLY);             // 4
  localparam int C_CNT_W          = C_IDX_W + 1;                    // 0..16
  localparam int C_SLOT_W         = $clog2(C_NUM_PORTS);            // 4
  localparam int C_WORD_W         = C_CTRL_W + C_DATA_W;            // 32
  localparam int C_LINE_W         = C_WORD_W * C_MULTIPLY;          // 512

  typedef struct packed {
    logic [C_CTRL_W-1:0] ctrl;
    logic [C_DATA_W-1:0] data;
  } pump_word_t;

  typedef logic [C_LINE_W-1:0] line_t;
endpackage

// File: rtl/swc_pktmem_wr_pump.sv
// Per-port write pump: collects up to 16 {ctrl,data} words, then offers them
// as one line for commit during the port's time slot.
//   Handshake: a word is taken at a posedge when drdy=1 and full=0; full stays
//   high from the 16th accept (or an accepted flush) until the cycle after the
//   commit edge.
//   Ports: clk, rst_n (async, active low), slot_hit (this port owns memory),
//   pagereq/pageaddr (new page, offset 0), data/ctrl/drdy (word in), flush
//   (commit partial pump), full, pageend (pulse after the page's last line),
//   commit (line being written this cycle), line_addr, line.
//   SWC_PKTMEM_FLUSH_ZERO_EN: unwritten positions of a flushed line read as 0;
//   otherwise they carry whatever the pump last held there.
module swc_pktmem_wr_pump
  import swc_pktmem_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 slot_hit,
  input  logic                 pagereq,
  input  logic [C_PAGE_AW-1:0] pageaddr,
  input  logic [C_DATA_W-1:0]  data,
  input  logic [C_CTRL_W-1:0]  ctrl,
  input  logic                 drdy,
  input  logic                 flush,
  output logic                 full,
  output logic                 pageend,
  output logic                 commit,
  output logic [C_LINE_AW-1:0] line_addr,
  output line_t                line
);
  logic [C_CNT_W-1:0]   cnt;
  logic [C_PAGE_AW-1:0] page;
  logic [C_OFFS_AW-1:0] offset;
  pump_word_t           words [C_MULTIPLY];
  logic                 accept;

  assign accept    = drdy & ~full;
  assign commit    = slot_hit & full;
  assign line_addr = {page, offset};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      full    <= 1'b0;
      page    <= '0;
      offset  <= '0;
      pageend <= 1'b0;
    end else begin
      pageend <= commit && (offset == C_OFFS_AW'(C_LINES_PER_PAGE - 1));
      if (commit) begin
        cnt    <= '0;
        full   <= 1'b0;
        offset <= offset + 1'b1;  // 4 lines per page: wraps 3 -> 0 by width
      end else if (accept) begin
        cnt  <= cnt + 1'b1;
        full <= (cnt == C_CNT_W'(C_MULTIPLY - 1)) | (flush & (cnt != '0));
      end else if (flush && (cnt != '0)) begin
        full <= 1'b1;
      end
      // A page request overrides the offset step; a same-cycle commit has
      // already used the old {page,offset}.
      if (pagereq) begin
        page   <= pageaddr;
        offset <= '0;
      end
    end
  end

  // Pump storage is not reset: a reset empties the pump through cnt.
  always_ff @(posedge clk) begin
    if (accept) words[cnt[C_IDX_W-1:0]] <= {ctrl, data};
  end

  always_comb begin
    line = '0;
    for (int i = 0; i < C_MULTIPLY; i++) begin
`ifdef SWC_PKTMEM_FLUSH_ZERO_EN
      line[i*C_WORD_W +: C_WORD_W] = (C_CNT_W'(i) < cnt) ? words[i] : '0;
`else
      line[i*C_WORD_W +: C_WORD_W] = words[i];
`endif
    end
  end
endmodule

// File: rtl/swc_packet_mem.sv
// Shared packet buffer of the switch core. Each port fills a write pump that is
// committed as a 512-bit line in the port's round-robin slot; read pumps fetch
// lines in the same slot and hand words out one by one.
//   Handshakes: write word accepted at posedge when wr_drdy_i=1 and
//   wr_full_o=0; read word popped at posedge when rd_dreq_i=1 and rd_drdy_o=1.
//   Ports (P = 11): clk_i, rst_n_i (async, active low); wr_pagereq_i,
//   wr_pageaddr_i, wr_pageend_o, wr_data_i, wr_ctrl_i, wr_drdy_i, wr_full_o,
//   wr_flush_i; rd_pagereq_i, rd_pageaddr_i, rd_pageend_o, rd_dreq_i,
//   rd_drdy_o, rd_data_o, rd_ctrl_o. Port n uses bits [16n+15:16n] of data/ctrl
//   and [10n+9:10n] of page addresses.
//   Feature macro: SWC_PKTMEM_FLUSH_ZERO_EN (zero-fill flushed lines).
module swc_packet_mem
  import swc_pktmem_pkg::*;
(
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic [C_NUM_PORTS-1:0]          wr_pagereq_i,
  input  logic [C_NUM_PORTS*C_PAGE_AW-1:0] wr_pageaddr_i,
  output logic [C_NUM_PORTS-1:0]          wr_pageend_o,
  input  logic [C_NUM_PORTS*C_DATA_W-1:0]  wr_data_i,
  input  logic [C_NUM_PORTS*C_CTRL_W-1:0]  wr_ctrl_i,
  input  logic [C_NUM_PORTS-1:0]          wr_drdy_i,
  output logic [C_NUM_PORTS-1:0]          wr_full_o,
  input  logic [C_NUM_PORTS-1:0]          wr_flush_i,
  input  logic [C_NUM_PORTS-1:0]          rd_pagereq_i,
  input  logic [C_NUM_PORTS*C_PAGE_AW-1:0] rd_pageaddr_i,
  output logic [C_NUM_PORTS-1:0]          rd_pageend_o,
  input  logic [C_NUM_PORTS-1:0]          rd_dreq_i,
  output logic [C_NUM_PORTS-1:0]          rd_drdy_o,
  output logic [C_NUM_PORTS*C_DATA_W-1:0]  rd_data_o,
  output logic [C_NUM_PORTS*C_CTRL_W-1:0]  rd_ctrl_o
);
  localparam int P = C_NUM_PORTS;

  logic [C_SLOT_W-1:0]  slot;
  logic [P-1:0]         wr_commit;
  logic [C_LINE_AW-1:0] wr_laddr [P];
  line_t                wr_line  [P];
  logic [P-1:0]         rd_fetch;
  logic [C_LINE_AW-1:0] rd_laddr [P];

  logic                 mem_we;
  logic [C_LINE_AW-1:0] mem_waddr;
  line_t                mem_wdata;
  logic                 mem_re;
  logic [C_LINE_AW-1:0] mem_raddr;
  line_t                mem_rdata;
  line_t                mem [C_NUM_LINES];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) slot <= '0;
    else          slot <= (slot == C_SLOT_W'(P - 1)) ? '0 : slot + 1'b1;
  end

  // Commit and fetch requests are qualified by the slot, so at most one port
  // drives each memory port in any cycle.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    mem_re    = 1'b0;
    mem_raddr = '0;
    for (int n = 0; n < P; n++) begin
      if (wr_commit[n]) begin
        mem_we    = 1'b1;
        mem_waddr = wr_laddr[n];
        mem_wdata = wr_line[n];
      end
      if (rd_fetch[n]) begin
        mem_re    = 1'b1;
        mem_raddr = rd_laddr[n];
      end
    end
  end

  // Non-blocking read and write in one block: same-address access is read-first.
  always_ff @(posedge clk_i) begin
    if (mem_re) mem_rdata <= mem[mem_raddr];
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  for (genvar n = 0; n < P; n++) begin : g_port
    swc_pktmem_wr_pump u_wr_pump (
      .clk       (clk_i),
      .rst_n     (rst_n_i),
      .slot_hit  (slot == C_SLOT_W'(n)),
      .pagereq   (wr_pagereq_i[n]),
      .pageaddr  (wr_pageaddr_i[n*C_PAGE_AW +: C_PAGE_AW]),
      .data      (wr_data_i[n*C_DATA_W +: C_DATA_W]),
      .ctrl      (wr_ctrl_i[n*C_CTRL_W +: C_CTRL_W]),
      .drdy      (wr_drdy_i[n]),
      .flush     (wr_flush_i[n]),
      .full      (wr_full_o[n]),
      .pageend   (wr_pageend_o[n]),
      .commit    (wr_commit[n]),
      .line_addr (wr_laddr[n]),
      .line      (wr_line[n])
    );

    // Read pump: pend marks the cycle mem_rdata belongs to this port. A page
    // request drops the pump and any in-flight fetch so egress always starts
    // on the requested page.
    logic [C_PAGE_AW-1:0] page;
    logic [C_OFFS_AW-1:0] offset;
    logic                 valid;
    logic                 pend;
    logic                 pageend_q;
    logic [C_IDX_W-1:0]   idx;
    pump_word_t           rd_buf [C_MULTIPLY];

    assign rd_fetch[n] = (slot == C_SLOT_W'(n)) & ~valid & ~pend & ~rd_pagereq_i[n];
    assign rd_laddr[n] = {page, offset};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        page      <= '0;
        offset    <= '0;
        valid     <= 1'b0;
        pend      <= 1'b0;
        pageend_q <= 1'b0;
        idx       <= '0;
      end else begin
        pageend_q <= rd_fetch[n] && (offset == C_OFFS_AW'(C_LINES_PER_PAGE - 1));
        if (rd_pagereq_i[n]) begin
          page   <= rd_pageaddr_i[n*C_PAGE_AW +: C_PAGE_AW];
          offset <= '0;
          valid  <= 1'b0;
          pend   <= 1'b0;
          idx    <= '0;
        end else begin
          if (rd_fetch[n]) begin
            pend   <= 1'b1;
            offset <= offset + 1'b1;
          end
          if (pend) begin
            pend  <= 1'b0;
            valid <= 1'b1;
            idx   <= '0;
          end else if (valid && rd_dreq_i[n]) begin
            idx <= idx + 1'b1;
            if (idx == C_IDX_W'(C_MULTIPLY - 1)) valid <= 1'b0;
          end
        end
      end
    end

    always_ff @(posedge clk_i) begin
      if (pend) begin
        for (int i = 0; i < C_MULTIPLY; i++) rd_buf[i] <= mem_rdata[i*C_WORD_W +: C_WORD_W];
      end
    end

    assign rd_pageend_o[n]                  = pageend_q;
    assign rd_drdy_o[n]                     = valid;
    assign rd_data_o[n*C_DATA_W +: C_DATA_W] = valid ? rd_buf[idx].data : '0;
    assign rd_ctrl_o[n*C_CTRL_W +: C_CTRL_W] = valid ? rd_buf[idx].ctrl : '0;
  end
endmodule

// File: tb/tb_swc_packet_mem.sv
// Testbench for swc_packet_mem: directed writes through the pumps, read-back
// through a scoreboard queue popped by a negedge monitor, slot-ownership and
// page-end tracking, flush corner cases and asynchronous reset.
module tb_swc_packet_mem;
  import swc_pktmem_pkg::*;
  localparam int P = C_NUM_PORTS;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [P-1:0]           wr_pagereq  = '0;
  logic [P*C_PAGE_AW-1:0] wr_pageaddr = '0;
  logic [P-1:0]           wr_pageend;
  logic [P*C_DATA_W-1:0]  wr_data     = '0;
  logic [P*C_CTRL_W-1:0]  wr_ctrl     = '0;
  logic [P-1:0]           wr_drdy     = '0;
  logic [P-1:0]           wr_full;
  logic [P-1:0]           wr_flush    = '0;
  logic [P-1:0]           rd_pagereq  = '0;
  logic [P*C_PAGE_AW-1:0] rd_pageaddr = '0;
  logic [P-1:0]           rd_pageend;
  logic [P-1:0]           rd_dreq     = '0;
  logic [P-1:0]           rd_drdy;
  logic [P*C_DATA_W-1:0]  rd_data;
  logic [P*C_CTRL_W-1:0]  rd_ctrl;

  swc_packet_mem dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .wr_pagereq_i(wr_pagereq), .wr_pageaddr_i(wr_pageaddr), .wr_pageend_o(wr_pageend),
    .wr_data_i(wr_data), .wr_ctrl_i(wr_ctrl), .wr_drdy_i(wr_drdy), .wr_full_o(wr_full),
    .wr_flush_i(wr_flush),
    .rd_pagereq_i(rd_pagereq), .rd_pageaddr_i(rd_pageaddr), .rd_pageend_o(rd_pageend),
    .rd_dreq_i(rd_dreq), .rd_drdy_o(rd_drdy), .rd_data_o(rd_data), .rd_ctrl_o(rd_ctrl)
  );

  // ---------------- scoreboard state ----------------
  logic [32:0] exp_q[$];      // {care, ctrl, data}
  int checks = 0;
  int errors = 0;
  int mon_port = 0;
  int mon_pops = 0;
  int wr_pe_cnt [P];
  int rd_pe_cnt [P];
  int m_slot;
  int prev_slot = 0;
  logic [P-1:0] prev_full = '0;

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference slot counter: slot n owns the memory in the cycle where it reads n.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_slot <= 0;
    else        m_slot <= (m_slot == P - 1) ? 0 : m_slot + 1;
  end

  initial begin
    for (int p = 0; p < P; p++) begin
      wr_pe_cnt[p] = 0;
      rd_pe_cnt[p] = 0;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [32:0] e;
    logic [31:0] got;
    if (rst_n) begin
      if (rd_drdy[mon_port] && rd_dreq[mon_port]) begin
        got = {rd_ctrl[mon_port*C_CTRL_W +: C_CTRL_W], rd_data[mon_port*C_DATA_W +: C_DATA_W]};
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_word_unexpected: got %h expected no word", got);
        end else begin
          e = exp_q.pop_front();
          if (e[32]) check("rd_word", got, e[31:0]);
        end
        mon_pops++;
      end
      for (int p = 0; p < P; p++) begin
        if (wr_pageend[p]) wr_pe_cnt[p]++;
        if (rd_pageend[p]) rd_pe_cnt[p]++;
        // wr_full falling means a commit happened at the edge closing prev cycle.
        if (prev_full[p] && !wr_full[p]) check("commit_slot", 32'(prev_slot), 32'(p));
      end
    end
    prev_full = wr_full;
    prev_slot = m_slot;
  end

  // ---------------- driver tasks (entered at posedge+2) ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(logic care, logic [15:0] c, logic [15:0] d);
    exp_q.push_back({care, c, d});
  endtask

  task automatic wr_page(int p, int page);
    wr_pagereq[p] = 1'b1;
    wr_pageaddr[p*C_PAGE_AW +: C_PAGE_AW] = C_PAGE_AW'(page);
    tick();
    wr_pagereq[p] = 1'b0;
  endtask

  task automatic rd_page(int p, int page);
    rd_pagereq[p] = 1'b1;
    rd_pageaddr[p*C_PAGE_AW +: C_PAGE_AW] = C_PAGE_AW'(page);
    tick();
    rd_pagereq[p] = 1'b0;
  endtask

  task automatic wr_word(int p, logic [15:0] d, logic [15:0] c);
    int n = 0;
    wr_data[p*C_DATA_W +: C_DATA_W] = d;
    wr_ctrl[p*C_CTRL_W +: C_CTRL_W] = c;
    while (wr_full[p] && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) check("wr_word_timeout", 32'(wr_full[p]), 0);
    wr_drdy[p] = 1'b1;
    tick();
    wr_drdy[p] = 1'b0;
  endtask

  task automatic wr_flush_pulse(int p);
    wr_flush[p] = 1'b1;
    tick();
    wr_flush[p] = 1'b0;
  endtask

  // wr_full must clear within 'budget' cycles (one full slot rotation).
  task automatic wait_full_clear(int p, int budget, string name);
    int n = 0;
    while (wr_full[p] && n < budget + 5) begin
      tick();
      n++;
    end
    check(name, 32'(n <= budget), 1);
  endtask

  task automatic wait_drdy(int p, int budget, string name);
    int n = 0;
    while (!rd_drdy[p] && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(rd_drdy[p]), 1);
  endtask

  task automatic rd_run(int p, int npops, int budget, output int cycles);
    int n = 0;
    mon_port = p;
    mon_pops = 0;
    rd_dreq[p] = 1'b1;
    while (mon_pops < npops && n < budget) begin
      tick();
      n++;
    end
    rd_dreq[p] = 1'b0;
    cycles = n;
    check("rd_pop_count", 32'(mon_pops), 32'(npops));
    check("rd_queue_empty", 32'(exp_q.size()), 0);
  endtask

  task automatic check_outputs_zero(string tag);
    check({tag, "_wr_full"}, 32'(wr_full), 0);
    check({tag, "_wr_pageend"}, 32'(wr_pageend), 0);
    check({tag, "_rd_drdy"}, 32'(rd_drdy), 0);
    check({tag, "_rd_pageend"}, 32'(rd_pageend), 0);
    for (int p = 0; p < P; p++)
      check({tag, "_rd_word"}, {rd_ctrl[p*C_CTRL_W +: C_CTRL_W], rd_data[p*C_DATA_W +: C_DATA_W]}, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    int base;
    int busy;

    repeat (3) @(posedge clk);
    #2;
    check_outputs_zero("reset");
    rst_n = 1'b1;
    tick();

    // Port 0: one full line, data 3..18, ctrl ffff, page 0.
    wr_page(0, 0);
    for (int i = 0; i < 16; i++) wr_word(0, 16'(3 + i), 16'hffff);
    check("p0_full_after_16", 32'(wr_full[0]), 1);
    wait_full_clear(0, 11, "p0_full_clear_11");
    for (int i = 0; i < 16; i++) push(1'b1, 16'hffff, 16'(3 + i));
    rd_page(0, 0);
    wait_drdy(0, 20, "p0_rd_drdy");
    rd_run(0, 16, 40, cyc);
    check("p0_rd_consecutive", 32'(cyc), 16);
    check("p0_rd_drdy_after_16", 32'(rd_drdy[0]), 0);

    // Port 1: 59 words + flush fill page 5; then 16 more words wrap to offset 0.
    wr_page(1, 5);
    base = wr_pe_cnt[1];
    for (int i = 0; i < 59; i++) wr_word(1, 16'(16'h0100 + i), 16'(16'h1000 + i));
    wr_flush_pulse(1);
    wait_full_clear(1, 12, "p1_flush_clear");
    tick();
    check("p1_pageend_once", 32'(wr_pe_cnt[1] - base), 1);
    for (int i = 0; i < 16; i++) wr_word(1, 16'(16'h0200 + i), 16'(16'h2000 + i));
    wait_full_clear(1, 11, "p1_wrap_clear");
    tick();
    check("p1_no_pageend_on_offset0", 32'(wr_pe_cnt[1] - base), 1);
    for (int i = 0; i < 16; i++) push(1'b1, 16'(16'h2000 + i), 16'(16'h0200 + i));
    for (int i = 16; i < 48; i++) push(1'b1, 16'(16'h1000 + i), 16'(16'h0100 + i));
    for (int j = 0; j < 16; j++) begin
      if (j < 11) push(1'b1, 16'(16'h1000 + 48 + j), 16'(16'h0100 + 48 + j));
`ifdef SWC_PKTMEM_FLUSH_ZERO_EN
      else push(1'b1, 16'h0000, 16'h0000);
`else
      // Stale pump positions still hold the previous line's words.
      else push(1'b1, 16'(16'h1000 + 32 + j), 16'(16'h0100 + 32 + j));
`endif
    end
    rd_page(1, 5);
    base = rd_pe_cnt[1];
    rd_run(1, 64, 300, cyc);
    check("p1_rd_pageend_once", 32'(rd_pe_cnt[1] - base), 1);

    // Port 2: 5 words then flush into page 7 offset 0.
    wr_page(2, 7);
    for (int i = 0; i < 5; i++) wr_word(2, 16'(16'h0300 + i), 16'(16'h3000 + i));
    wr_flush_pulse(2);
    wait_full_clear(2, 12, "p2_flush_clear");
    for (int i = 0; i < 5; i++) push(1'b1, 16'(16'h3000 + i), 16'(16'h0300 + i));
    for (int i = 5; i < 16; i++) begin
`ifdef SWC_PKTMEM_FLUSH_ZERO_EN
      push(1'b1, 16'h0000, 16'h0000);
`else
      push(1'b0, 16'h0000, 16'h0000);
`endif
    end
    rd_page(2, 7);
    rd_run(2, 16, 60, cyc);

    // Port 3: flush on empty pump and flush while full are both ignored.
    wr_page(3, 9);
    base = wr_pe_cnt[3];
    wr_flush_pulse(3);
    check("p3_empty_flush_ignored", 32'(wr_full[3]), 0);
    for (int i = 0; i < 16; i++) wr_word(3, 16'(16'h0400 + i), 16'(16'h4000 + i));
    wr_flush_pulse(3);
    wait_full_clear(3, 11, "p3_full_clear");
    busy = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (wr_full[3]) busy++;
    end
    check("p3_full_flush_ignored", 32'(busy), 0);
    check("p3_no_pageend", 32'(wr_pe_cnt[3] - base), 0);

    // All ports write a full line at once; each must commit in its own slot.
    for (int p = 0; p < P; p++) begin
      wr_pagereq[p] = 1'b1;
      wr_pageaddr[p*C_PAGE_AW +: C_PAGE_AW] = C_PAGE_AW'(20 + p);
    end
    tick();
    wr_pagereq = '0;
    for (int i = 0; i < 16; i++) begin
      for (int p = 0; p < P; p++) begin
        wr_data[p*C_DATA_W +: C_DATA_W] = 16'(p * 256 + i);
        wr_ctrl[p*C_CTRL_W +: C_CTRL_W] = 16'hc000 | 16'(p * 256 + i);
      end
      wr_drdy = '1;
      tick();
    end
    wr_drdy = '0;
    check("all_full_after_16", 32'(wr_full), 32'((1 << P) - 1));
    busy = 0;
    while (wr_full != '0 && busy < 16) begin
      tick();
      busy++;
    end
    check("all_full_clear", 32'(wr_full), 0);
    for (int p = 0; p < P; p++) begin
      for (int i = 0; i < 16; i++) push(1'b1, 16'hc000 | 16'(p * 256 + i), 16'(p * 256 + i));
      rd_page(p, 20 + p);
      rd_run(p, 16, 60, cyc);
    end

    // Asynchronous reset while a read word is presented and a write is partial.
    rd_page(0, 0);
    wait_drdy(0, 20, "rst_pre_rd_drdy");
    wr_page(4, 30);
    for (int i = 0; i < 7; i++) wr_word(4, 16'(16'h0ee0 + i), 16'h0eee);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async_rst");
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    tick();
    wr_page(4, 30);
    for (int i = 0; i < 16; i++) wr_word(4, 16'(16'h0500 + i), 16'(16'h5000 + i));
    wait_full_clear(4, 11, "p4_post_rst_clear");
    for (int i = 0; i < 16; i++) push(1'b1, 16'(16'h5000 + i), 16'(16'h0500 + i));
    rd_page(4, 30);
    rd_run(4, 16, 60, cyc);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
